// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its predecoder.
// Covers the opcode map, FSM encoding and predecode payload.
package if_fetch_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 2;

    localparam logic [OPC_W-1:0] OP_ALU    = 2'b00;
    localparam logic [OPC_W-1:0] OP_LOAD   = 2'b01;
    localparam logic [OPC_W-1:0] OP_BRANCH = 2'b10;
    localparam logic [OPC_W-1:0] OP_HALT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic write_reg;
        logic signal_to_reg;
        logic is_halt;
    } predec_t;

    // The opcode lives in the top bits of every instruction word.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// IF-stage handshake bundle: control/program-load inputs and the IF/ID payload.
// The slave modport belongs to the fetch stage and the master modport to its environment.
interface if_fetch_if #(
    parameter int unsigned PC_W = 4
) ();
    import if_fetch_pkg::*;

    logic                 start;
    logic                 ready_in;
    logic                 redirect_valid;
    logic [PC_W-1:0]      redirect_target;
    logic                 imem_we;
    logic [PC_W-1:0]      imem_waddr;
    logic [INSTR_W-1:0]   imem_wdata;

    logic [INSTR_W-1:0]   instruction_out;
    logic                 writeReg_out;
    logic                 signaltoReg_out;
    logic [PC_W-1:0]      pc_out;
    logic                 valid_out;
    logic                 halted;

    modport master (
        output start, ready_in, redirect_valid, redirect_target,
               imem_we, imem_waddr, imem_wdata,
        input  instruction_out, writeReg_out, signaltoReg_out,
               pc_out, valid_out, halted
    );

    modport slave (
        input  start, ready_in, redirect_valid, redirect_target,
               imem_we, imem_waddr, imem_wdata,
        output instruction_out, writeReg_out, signaltoReg_out,
               pc_out, valid_out, halted
    );

endinterface

// File: rtl/if_fetch_predecode.sv
// Combinational predecode of an instruction word into writeback control bits.
// Shared with the decode stage so both interpret opcodes identically.
module if_fetch_predecode
    import if_fetch_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output predec_t            predec_c_o
);

    logic [OPC_W-1:0] opcode;
    logic             unused_operand;

    assign opcode         = opcode_of(instr_i);
    assign unused_operand = ^instr_i[INSTR_W-OPC_W-1:0];

    // ALU and LOAD write a register; only LOAD takes its writeback from memory.
    assign predec_c_o.write_reg     = (opcode == OP_ALU) || (opcode == OP_LOAD);
    assign predec_c_o.signal_to_reg = (opcode == OP_LOAD);
    assign predec_c_o.is_halt       = (opcode == OP_HALT);

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, instruction memory and the registered IF/ID
// producer outputs, with stall, branch redirect and halt handling.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned PC_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    if_fetch_if.slave  fetch_if
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               write_reg_q, write_reg_d;
    logic               signal_to_reg_q, signal_to_reg_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;

    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];
    logic [INSTR_W-1:0] fetch_word;
    predec_t            fetch_pd;

    // Asynchronous read; a same-cycle write lands at the edge so the fetch sees old data.
    assign fetch_word = mem_q[pc_q];

    always_ff @(posedge clk) begin
        if (reset && fetch_if.imem_we) begin
            mem_q[fetch_if.imem_waddr] <= fetch_if.imem_wdata;
        end
    end

    if_fetch_predecode u_predecode (
        .instr_i    (fetch_word),
        .predec_c_o (fetch_pd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            instr_q         <= '0;
            write_reg_q     <= 1'b0;
            signal_to_reg_q <= 1'b0;
            pc_out_q        <= '0;
            valid_q         <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            write_reg_q     <= write_reg_d;
            signal_to_reg_q <= signal_to_reg_d;
            pc_out_q        <= pc_out_d;
            valid_q         <= valid_d;
            halted_q        <= halted_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        write_reg_d     = write_reg_q;
        signal_to_reg_d = signal_to_reg_q;
        pc_out_d        = pc_out_q;
        valid_d         = valid_q;
        halted_d        = halted_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (fetch_if.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                // Redirect wins over stall: the bubble is inserted even when IF/ID is full.
                if (fetch_if.redirect_valid) begin
                    pc_d    = fetch_if.redirect_target;
                    valid_d = 1'b0;
                end else if (fetch_if.ready_in) begin
                    instr_d         = fetch_word;
                    write_reg_d     = fetch_pd.write_reg;
                    signal_to_reg_d = fetch_pd.signal_to_reg;
                    pc_out_d        = pc_q;
                    valid_d         = 1'b1;
                    if (fetch_pd.is_halt) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            HALT: begin
                halted_d = 1'b1;
                if (fetch_if.ready_in) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_if.instruction_out = instr_q;
    assign fetch_if.writeReg_out    = write_reg_q;
    assign fetch_if.signaltoReg_out = signal_to_reg_q;
    assign fetch_if.pc_out          = pc_out_q;
    assign fetch_if.valid_out       = valid_q;
    assign fetch_if.halted          = halted_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the fetch stage.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PW    = 4;

    logic clk = 1'b0;
    logic reset;

    if_fetch_if #(.PC_W(PW)) bus ();

    if_fetch #(.IMEM_DEPTH(DEPTH), .PC_W(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model: mode 0 = waiting for start, 1 = fetching, 2 = stopped on HALT.
    int         m_mode;
    int         m_pc;
    int         m_pcout;
    logic [7:0] m_instr;
    logic       m_wr;
    logic       m_s2r;
    logic       m_valid;
    logic [7:0] m_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rdy, input logic rv, input int rt,
                         input logic we, input int wa, input logic [7:0] wd);
        bus.start           = st;
        bus.ready_in        = rdy;
        bus.redirect_valid  = rv;
        bus.redirect_target = PW'(rt);
        bus.imem_we         = we;
        bus.imem_waddr      = PW'(wa);
        bus.imem_wdata      = wd;
    endtask

    // One clock: advance the model on the edge, then compare every output.
    task automatic cycle();
        logic [7:0] word;
        int         opc;
        @(posedge clk);
        word = m_mem[m_pc];
        opc  = int'(word) / 64;
        if (!reset) begin
            m_mode = 0; m_pc = 0; m_pcout = 0;
            m_instr = 8'h00; m_wr = 1'b0; m_s2r = 1'b0; m_valid = 1'b0;
        end else begin
            if (m_mode == 0) begin
                m_valid = 1'b0;
                if (bus.start) begin m_mode = 1; m_pc = 0; end
            end else if (m_mode == 1) begin
                if (bus.redirect_valid) begin
                    m_pc    = int'(bus.redirect_target);
                    m_valid = 1'b0;
                end else if (bus.ready_in) begin
                    m_instr = word;
                    m_wr    = (opc < 2);
                    m_s2r   = (opc == 1);
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                    if (opc == 3) m_mode = 2;
                    else          m_pc = (m_pc + 1) % DEPTH;
                end
            end else if (bus.ready_in) begin
                m_valid = 1'b0;
            end
            if (bus.imem_we) m_mem[int'(bus.imem_waddr)] = bus.imem_wdata;
        end
        #1;
        chk("instruction_out", 32'(bus.instruction_out), 32'(m_instr));
        chk("writeReg_out",    32'(bus.writeReg_out),    32'(m_wr));
        chk("signaltoReg_out", 32'(bus.signaltoReg_out), 32'(m_s2r));
        chk("pc_out",          32'(bus.pc_out),          32'(m_pcout));
        chk("valid_out",       32'(bus.valid_out),       32'(m_valid));
        chk("halted",          32'(bus.halted),          32'(m_mode == 2));
    endtask

    function automatic logic [7:0] rand_word();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        if (w >= 8'hC0 && $urandom_range(0, 3) != 0) w = w & 8'h3F;
        return w;
    endfunction

    logic [7:0] prog [4];

    initial begin
        vectors = 0; miscompares = 0;
        m_mode = 0; m_pc = 0; m_pcout = 0;
        m_instr = 8'h00; m_wr = 1'b0; m_s2r = 1'b0; m_valid = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 8'h00;
        prog[0] = 8'h05; prog[1] = 8'h43; prog[2] = 8'h81; prog[3] = 8'hC0;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        reset = 1'b0;
        cycle(); cycle();
        chk("rst_instr", 32'(bus.instruction_out), 32'h00);
        chk("rst_valid", 32'(bus.valid_out), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_pc", 32'(bus.pc_out), 32'h0);
        reset = 1'b1;

        // Program load and straight-line run to HALT
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(0, 0, 0, 0, 1, i, (i < 4) ? prog[i] : 8'h00);
            cycle();
        end
        drive(1, 0, 0, 0, 0, 0, 8'h00); cycle();
        chk("first_run_valid", 32'(bus.valid_out), 32'h0);
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        cycle();
        chk("p0_pc", 32'(bus.pc_out), 32'd0);  chk("p0_instr", 32'(bus.instruction_out), 32'h05);
        chk("p0_wr", 32'(bus.writeReg_out), 32'h1); chk("p0_s2r", 32'(bus.signaltoReg_out), 32'h0);
        cycle();
        chk("p1_pc", 32'(bus.pc_out), 32'd1);  chk("p1_instr", 32'(bus.instruction_out), 32'h43);
        chk("p1_wr", 32'(bus.writeReg_out), 32'h1); chk("p1_s2r", 32'(bus.signaltoReg_out), 32'h1);
        cycle();
        chk("p2_pc", 32'(bus.pc_out), 32'd2);  chk("p2_instr", 32'(bus.instruction_out), 32'h81);
        chk("p2_wr", 32'(bus.writeReg_out), 32'h0);
        cycle();
        chk("p3_pc", 32'(bus.pc_out), 32'd3);  chk("p3_instr", 32'(bus.instruction_out), 32'hC0);
        chk("p3_valid", 32'(bus.valid_out), 32'h1); chk("p3_halted", 32'(bus.halted), 32'h1);
        cycle();
        chk("halt_bubble", 32'(bus.valid_out), 32'h0); chk("halt_pc", 32'(bus.pc_out), 32'd3);
        drive(1, 1, 1, 0, 0, 0, 8'h00); cycle(); cycle();
        chk("halt_ignore_valid", 32'(bus.valid_out), 32'h0);
        chk("halt_ignore_instr", 32'(bus.instruction_out), 32'hC0);
        chk("halt_ignore_halted", 32'(bus.halted), 32'h1);

        // Stall while pc_out=1
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        reset = 1'b0; cycle(); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1, i, 8'h00); cycle(); end
        drive(1, 0, 0, 0, 0, 0, 8'h00); cycle();
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle(); cycle();
        chk("pre_stall_pc", 32'(bus.pc_out), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_pc", 32'(bus.pc_out), 32'd1);
            chk("stall_valid", 32'(bus.valid_out), 32'h1);
        end
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle();
        chk("release_pc", 32'(bus.pc_out), 32'd2);

        // Redirect, with and without downstream stall
        drive(0, 1, 1, 6, 0, 0, 8'h00); cycle();
        chk("redir_bubble", 32'(bus.valid_out), 32'h0); chk("redir_hold_pc", 32'(bus.pc_out), 32'd2);
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle();
        chk("redir_pc", 32'(bus.pc_out), 32'd6); chk("redir_valid", 32'(bus.valid_out), 32'h1);
        drive(0, 0, 1, 6, 0, 0, 8'h00); cycle();
        chk("redir_stall_bubble", 32'(bus.valid_out), 32'h0);
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle();
        chk("redir_stall_pc", 32'(bus.pc_out), 32'd6);

        // PC wrap-around
        drive(0, 1, 1, 14, 0, 0, 8'h00); cycle();
        drive(0, 1, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("wrap_pc", 32'(bus.pc_out), 32'((14 + k) % 16));
        end

        // Reset mid-run, then no start
        reset = 1'b0; cycle(); reset = 1'b1;
        chk("midrst_instr", 32'(bus.instruction_out), 32'h00);
        chk("midrst_pc", 32'(bus.pc_out), 32'd0);
        chk("midrst_wr", 32'(bus.writeReg_out), 32'h0);
        chk("midrst_valid", 32'(bus.valid_out), 32'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_valid", 32'(bus.valid_out), 32'h0);
        end

        // Same-cycle write and fetch at the current PC
        drive(0, 0, 0, 0, 1, 3, 8'h05); cycle();
        drive(1, 0, 0, 0, 0, 0, 8'h00); cycle();
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle(); cycle(); cycle();
        chk("wf_pre_pc", 32'(bus.pc_out), 32'd2);
        drive(0, 1, 0, 0, 1, 3, 8'hC0); cycle();
        chk("wf_old_instr", 32'(bus.instruction_out), 32'h05);
        chk("wf_old_pc", 32'(bus.pc_out), 32'd3);
        chk("wf_not_halted", 32'(bus.halted), 32'h0);
        drive(0, 1, 1, 3, 0, 0, 8'h00); cycle();
        drive(0, 1, 0, 0, 0, 0, 8'h00); cycle();
        chk("wf_new_instr", 32'(bus.instruction_out), 32'hC0);
        chk("wf_new_halted", 32'(bus.halted), 32'h1);
        chk("wf_new_valid", 32'(bus.valid_out), 32'h1);

        // Random traffic against the model
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        reset = 1'b0; cycle(); reset = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            drive(0, 0, 0, 0, 1, i, rand_word()); cycle();
        end
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(0, 4) == 0, int'($urandom_range(0, DEPTH - 1)), rand_word());
            reset = ($urandom_range(0, 49) != 0) && !(m_mode == 2 && $urandom_range(0, 7) == 0);
            cycle();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 8-bit RISC pipeline; the producer side of the IF/ID pipeline register.
- Holds the PC and a small instruction memory, and predecodes the writeReg/signaltoReg control bits.
- Presents one registered instruction per cycle with a valid flag.
- Honours downstream stall (ready), branch redirect and halt.

Parameters:
- IMEM_DEPTH, 16, number of 8-bit instruction words; power of 2, at least 2.
- PC_W, 4, PC width; must equal log2(IMEM_DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- start  input  1  leaves IDLE and begins fetching at PC 0.
- ready_in  input  1  IF/ID can accept; 0 = stall.
- redirect_valid  input  1  branch taken; load the PC from redirect_target.
- redirect_target  input  PC_W  branch target address.
- imem_we  input  1  instruction memory write enable (program load).
- imem_waddr  input  PC_W  write address.
- imem_wdata  input  8  write data.
- instruction_out  output  8  fetched instruction.
- writeReg_out  output  1  predecoded register-write enable.
- signaltoReg_out  output  1  predecoded writeback-source select.
- pc_out  output  PC_W  address of instruction_out.
- valid_out  output  1  outputs hold a real instruction.
- halted  output  1  FSM is in HALT.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE, PC=0, instruction_out=0, writeReg_out=0, signaltoReg_out=0, pc_out=0, valid_out=0, halted=0.
  - Instruction memory contents are not cleared.
  - Reset overrides every other input, including mid-RUN.
- Instruction format: opcode = instr[7:6].
- Predecode:
  - 00 ALU: writeReg=1, signaltoReg=0.
  - 01 LOAD: writeReg=1, signaltoReg=1.
  - 10 BRANCH: writeReg=0, signaltoReg=0.
  - 11 HALT: writeReg=0, signaltoReg=0.
- FSM states: IDLE, RUN, HALT.
  - IDLE: valid_out=0; start=1 -> RUN with PC=0. First valid output appears on the edge after the first RUN cycle (1-cycle fetch latency).
  - RUN, redirect_valid=1 (highest priority after reset): PC <= redirect_target; valid_out <= 0 (bubble); other outputs hold. Applies even when ready_in=0.
  - RUN, ready_in=0 and no redirect: PC and all outputs hold. valid_out does not drop during a stall.
  - RUN, ready_in=1:
    - Outputs <= mem[PC] plus its predecode; pc_out <= PC; valid_out <= 1.
    - PC <= PC+1, modulo IMEM_DEPTH (wraps from DEPTH-1 to 0).
    - If the fetched opcode is HALT: the HALT instruction is emitted with valid_out=1 and the FSM goes to HALT; the PC is not incremented.
  - HALT: halted=1.
    - On the first ready_in=1 cycle, valid_out <= 0; all other outputs hold.
    - start and redirect are ignored. Exit only via reset.
- start is ignored outside IDLE.
- Instruction memory:
  - Combinational read at PC; synchronous write.
  - Writes are allowed in any state.
  - Write and fetch to the same address in the same cycle: the fetch returns the old data.
- Outputs are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - opcode constants OP_ALU=2'b00, OP_LOAD=2'b01, OP_BRANCH=2'b10, OP_HALT=2'b11;
  - FSM state encoding (IDLE, RUN, HALT);
  - INSTR_W=8.
- One natural sub-module: if_predecode, combinational (instruction -> writeReg, signaltoReg, is_halt). Reused by the decode stage.

Test Plan:
- Load mem = {0x05, 0x43, 0x81, 0xC0}, reset, start -> on successive cycles:
  - pc_out=0, instr=0x05, wr=1, s2r=0;
  - pc_out=1, instr=0x43, wr=1, s2r=1;
  - pc_out=2, instr=0x81, wr=0;
  - pc_out=3, instr=0xC0, then halted=1.
  - Then valid_out=0 and outputs frozen.
- Hold ready_in=0 for 3 cycles while pc_out=1 -> outputs and PC are unchanged. Release -> pc_out=2 on the next cycle.
- Assert redirect_valid with target=6 while in RUN -> one cycle with valid_out=0, next output has pc_out=6. Repeat with ready_in=0 -> the redirect still takes effect.
- IMEM_DEPTH=16, all memory 0x00, start -> pc_out sequence 14, 15, 0, 1 (wrap-around).
- Assert reset=0 for one edge mid-RUN -> all outputs 0, state IDLE. Without start, valid_out stays 0 for 5 cycles.
- In the same cycle, imem_we at the current PC with wdata=0xC0 while mem holds 0x05 -> 0x05 is emitted. Redirect back to that address -> 0xC0 is fetched and the FSM halts.
